// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
//
// Multiply/divide resource controller that sits beside the Execute stage of the
// 5-stage MIPS pipeline. It owns the HI/LO registers. It sequences MULT/MULTU/
// DIV/DIVU as multi-cycle operations timed by a down-counter. It applies
// MTHI/MTLO in a single cycle. It asks the hazard unit to stall whenever the
// D-stage instruction touches HI/LO while a long operation is running or is
// being started.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous, active-high; clears all state
//   md_start   in   E-stage instruction is an MD op (valid this cycle)
//   md_op      in   [2:0] 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 ignored
//   src_a      in   [31:0] forwarded rs value from E
//   src_b      in   [31:0] forwarded rt value from E
//   d_uses_md  in   D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//   busy       out  long operation in progress
//   stall_md   out  stall request to hazard unit (combinational)
//   done       out  one-cycle pulse on the cycle HI/LO hold a new mult/div result
//   hi, lo     out  [31:0] HI and LO registers
// -----------------------------------------------------------------------------
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   a_q, a_nxt;
  logic [31:0]   b_q, b_nxt;
  logic [1:0]    op_q, op_nxt;     // ops 0..3 only, so two bits suffice
  logic [31:0]   hi_q, hi_nxt;
  logic [31:0]   lo_q, lo_nxt;
  logic          done_q, done_nxt;

  // Result datapath, driven only from the latched operands.
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur;
  logic [31:0] res_hi, res_lo;

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    prod   = '0;
    a_mag  = a_q[31] ? -a_q : a_q;
    b_mag  = b_q[31] ? -b_q : b_q;
    // Signed divide runs on magnitudes and fixes signs afterwards. This also
    // covers 0x80000000 / -1: the magnitude quotient 0x80000000 keeps that
    // value after negation, and the remainder is 0.
    dvd    = op_q[0] ? a_q : a_mag;
    dvs    = op_q[0] ? b_q : b_mag;
    uq     = '0;
    ur     = '0;
    res_hi = '0;
    res_lo = '0;

    if (!op_q[1]) begin
      // MULT sign-extends and MULTU zero-extends to 64 bits. The low 64 bits of
      // the 64x64 product are then the exact signed or unsigned product.
      if (op_q[0]) prod = {32'h0, a_q} * {32'h0, b_q};
      else         prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_q == 32'h0) begin
      // Divide by zero gives a defined result and never X.
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      uq = dvd / dvs;
      ur = dvd % dvs;
      if (!op_q[0]) begin
        res_lo = (a_q[31] ^ b_q[31]) ? -uq : uq;  // truncate toward zero
        res_hi = a_q[31] ? -ur : ur;              // remainder follows dividend
      end else begin
        res_lo = uq;
        res_hi = ur;
      end
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_nxt     = src_a;
              b_nxt     = src_b;
              op_nxt    = md_op[1:0];
              count_nxt = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state_nxt = BUSY;
            end
            3'd4:    hi_nxt = src_a;
            3'd5:    lo_nxt = src_a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // md_start is ignored here. The stall request keeps new MD ops out of E.
        if (count == CW'(1)) begin
          hi_nxt    = res_hi;
          lo_nxt    = res_lo;
          done_nxt  = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      op_q   <= op_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy = (state == BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // MTHI/MTLO in E never stall. HI/LO are written at the edge before the
  // D-stage mfhi/mflo reads them in E.
  assign stall_md = d_uses_md & (busy | (md_start & ~md_op[2]));

endmodule
